// File: rtl/version_pkg.sv
// Build identity constants stamped at synthesis time.
// Date/time fields are BCD so they read naturally in a hex dump.
package version_pkg;

  localparam logic [7:0]  MAJOR  = 8'h00;
  localparam logic [7:0]  MINOR  = 8'h00;
  localparam logic [7:0]  PATCH  = 8'h00;
  localparam logic [7:0]  BUILD  = 8'h41;
  localparam logic [15:0] YEAR   = 16'h2025;
  localparam logic [7:0]  MONTH  = 8'h11;
  localparam logic [7:0]  DAY    = 8'h10;
  localparam logic [7:0]  HOUR   = 8'h11;
  localparam logic [7:0]  MINUTE = 8'h22;
  localparam logic [7:0]  SECOND = 8'h55;

endpackage

// File: rtl/version_report_pkg.sv
// Frame layout, FSM state type and payload byte mapping for version_reporter.
package version_report_pkg;

  import version_pkg::*;

  localparam int unsigned C_FRAME_LEN = 13;
  localparam int unsigned C_IDX_W     = 4;
  localparam logic [7:0]  C_SOF       = 8'h56;
  localparam logic [C_IDX_W-1:0] C_LAST_PAYLOAD_IDX = 4'd11;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CKSUM} state_t;

  // Index 0 (SOF) and 12 (checksum) are produced by the FSM, not here.
  function automatic logic [7:0] payload_byte(input logic [C_IDX_W-1:0] idx);
    logic [7:0] b;
    case (idx)
      4'd1:    b = MAJOR;
      4'd2:    b = MINOR;
      4'd3:    b = PATCH;
      4'd4:    b = BUILD;
      4'd5:    b = YEAR[15:8];
      4'd6:    b = YEAR[7:0];
      4'd7:    b = MONTH;
      4'd8:    b = DAY;
      4'd9:    b = HOUR;
      4'd10:   b = MINUTE;
      4'd11:   b = SECOND;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/version_reporter_if.sv
// Valid/ready byte stream carrying the version report frame.
interface version_reporter_if;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/version_report_timer.sv
// Free-running 0..PERIOD_CYCLES-1 counter emitting a one-cycle tick on wrap.
// PERIOD_CYCLES=0 parks the counter at zero and never ticks.
module version_report_timer #(
  parameter logic [31:0] PERIOD_CYCLES = 32'd0
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam logic [31:0] C_TOP = (PERIOD_CYCLES == 32'd0) ? 32'd0 : PERIOD_CYCLES - 32'd1;
  localparam logic        C_EN  = (PERIOD_CYCLES != 32'd0);

  logic [31:0] r_count;
  logic        w_wrap;

  assign w_wrap = (r_count == C_TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wrap) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_tick = C_EN && w_wrap;

endmodule

// File: rtl/version_reporter.sv
// Streams build-version constants as a 13-byte SOF/payload/checksum frame,
// on request or periodically, over a valid/ready byte interface.
module version_reporter
  import version_report_pkg::*;
#(
  parameter logic [31:0] PERIOD_CYCLES = 32'd0,
  parameter logic [7:0]  SOF_BYTE      = C_SOF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  version_reporter_if.master        m_if,
  output logic                      busy,
  output logic [15:0]               frame_count
);

  state_t             r_state;
  state_t             w_state_next;
  logic [C_IDX_W-1:0] r_idx;
  logic [7:0]         r_cksum;
  logic               r_pending;
  logic [15:0]        r_frame_count;

  logic       w_tick;
  logic       w_trig;
  logic       w_start;
  logic       w_hs;
  logic       w_valid;
  logic       w_last;
  logic [7:0] w_data;

  version_report_timer #(
    .PERIOD_CYCLES (PERIOD_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  // A timer tick and an external req in the same cycle collapse into one request.
  assign w_trig = req || w_tick;
  assign w_hs   = w_valid && m_if.m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pending || w_trig) begin
          w_state_next = ST_SEND;
          w_start      = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_hs && (r_idx == C_LAST_PAYLOAD_IDX)) begin
          w_state_next = ST_CKSUM;
        end
      end
      ST_CKSUM: begin
        // Chain straight into the next SOF so queued frames leave no gap.
        if (w_hs) begin
          if (r_pending || w_trig) begin
            w_state_next = ST_SEND;
            w_start      = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    w_data  = 8'h00;
    case (r_state)
      ST_SEND: begin
        w_valid = 1'b1;
        w_data  = (r_idx == '0) ? SOF_BYTE : payload_byte(r_idx);
      end
      ST_CKSUM: begin
        w_valid = 1'b1;
        w_last  = 1'b1;
        w_data  = 8'h00 - r_cksum;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx         <= '0;
      r_cksum       <= '0;
      r_pending     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      if (w_start) begin
        r_idx <= '0;
      end else if ((r_state == ST_SEND) && w_hs) begin
        r_idx <= r_idx + 4'd1;
      end

      if ((r_state == ST_SEND) && w_hs) begin
        r_cksum <= (r_idx == '0) ? 8'h00 : (r_cksum + payload_byte(r_idx));
      end

      if (w_start) begin
        r_pending <= 1'b0;
      end else if (w_trig && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end

      if ((r_state == ST_CKSUM) && w_hs) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  assign m_if.m_valid = w_valid;
  assign m_if.m_last  = w_last;
  assign m_if.m_data  = w_data;
  assign busy         = (r_state != ST_IDLE) || r_pending;
  assign frame_count  = r_frame_count;

endmodule

// File: doc/version_reporter.md
Name: version_reporter

Overview:
- Sequences the build-version constants from version_pkg (major, minor, patch, build, year, month, day, hour, minute, second) onto an 8-bit valid/ready byte stream as one framed, checksummed report.
- Sits between version_pkg and the host-link byte mux (UART/debug TX). Firmware or the host can read back build identity on demand or periodically.
- Frame format: SOF byte, 11 payload bytes, checksum byte. 13 bytes total.

Parameters:
- PERIOD_CYCLES, 0, automatic report interval in clk cycles; 0 disables periodic reports. 32-bit unsigned.
- SOF_BYTE, 8'h56, start-of-frame marker ('V').

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  single-cycle report request.
- m_data  out  8  stream byte.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts byte when m_valid && m_ready.
- m_last  out  1  high on the checksum byte (frame end).
- busy  out  1  frame in progress or request pending.
- frame_count  out  16  completed frames; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_last=0, m_data=0, busy=0, frame_count=0, pending=0, period timer=0, state=IDLE. Reset asserted mid-frame aborts the frame; no partial-frame resume.
- Byte order: 0=SOF_BYTE, 1=MAJOR, 2=MINOR, 3=PATCH, 4=BUILD, 5=YEAR[15:8], 6=YEAR[7:0], 7=MONTH, 8=DAY, 9=HOUR, 10=MINUTE, 11=SECOND, 12=CHECKSUM.
- CHECKSUM = (0 - sum(bytes 1..11)) mod 256. Sum of bytes 1..12 is therefore 0 mod 256. SOF is excluded.
- Checksum accumulator: 8-bit, updated on each accepted payload byte, cleared on SOF accept.
- States:
  - IDLE: m_valid=0. If pending or req, go to SEND with index=0. m_valid rises the cycle after req (latency 1).
  - SEND: m_valid=1, m_data=byte[index]. On handshake: index<11 -> index+1; index==11 -> CKSUM.
  - CKSUM: m_valid=1, m_last=1, m_data=checksum. On handshake: frame_count+1, then IDLE, or SEND directly if pending. Back-to-back frames need no idle cycle.
- Stream rules:
  - m_data, m_last and m_valid stay stable while m_valid && !m_ready.
  - m_valid never drops without a handshake, except on reset.
- Request handling:
  - req while busy sets a one-deep pending flag. Further reqs while pending is set are merged.
  - pending clears when the next frame starts (SOF presented).
  - req in IDLE starts immediately and does not set pending.
- Periodic timer (PERIOD_CYCLES>0):
  - Free-running counter 0..PERIOD_CYCLES-1; on wrap, raises a trigger equivalent to req.
  - Timer trigger coinciding with req merges into a single request.
  - PERIOD_CYCLES=1 triggers every cycle, so frames stream back-to-back.
- busy = (state!=IDLE) || pending.
- Constants are sampled combinationally from version_pkg; no register copy is needed.

Decomposition:
- version_report_pkg holds:
  - C_FRAME_LEN=13, C_IDX_W=4, C_SOF default.
  - typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_CKSUM} state_t.
  - function payload_byte(idx) returning the version_pkg field for indices 1..11.
- One sub-module: version_report_timer (PERIOD_CYCLES counter, one-cycle tick output, tied off when PERIOD_CYCLES=0).

Test Plan:
- Constants 0.0.0 build 65 (8'h41), 2025-11-10 11:22:55; req pulse with m_ready=1 -> 56 00 00 00 41 20 25 11 10 11 22 55 D1. m_last only on D1; m_valid first high 1 cycle after req; frame_count=1.
- Same frame with m_ready randomly low 50% -> identical 13 bytes; data and m_last held stable during every stall.
- req during byte 5, and again during byte 9 -> exactly two frames back-to-back (SOF follows D1 with no gap); frame_count=2; busy low only after the second D1 handshake.
- PERIOD_CYCLES=100, m_ready=1, no req -> a SOF appears every 100 cycles; req coinciding with a timer tick yields one frame, not two.
- rst asserted while m_valid=1 at byte 7 -> outputs 0 in the same cycle; after release, req yields a full fresh frame starting at 56; frame_count restarted at 0.
- Force frame_count to 16'hFFFF, complete one frame -> frame_count=0.
